// File: rtl/reg_file_sb.sv
// Two-read/one-write register file with write-through bypass and a per-entry busy scoreboard.
// Decode reserves a destination on issue; writeback writes the data and releases the entry.
module reg_file_sb #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter bit ZERO_REG = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              RegWrite,
   input  logic [ADDR_W-1:0] WN,
   input  logic [DATA_W-1:0] WD,
   input  logic [ADDR_W-1:0] RN1,
   input  logic [ADDR_W-1:0] RN2,
   output logic [DATA_W-1:0] RD1,
   output logic [DATA_W-1:0] RD2,
   input  logic              Rsv,
   input  logic [ADDR_W-1:0] RsvN,
   output logic              busy1,
   output logic              busy2,
   output logic [ADDR_W:0]   busy_cnt,
   output logic              wr_unres
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DEPTH-1:0]  busy_q, busy_d;
   logic [ADDR_W:0]   busy_cnt_q, busy_cnt_d;
   logic              wr_unres_q, wr_unres_d;

   logic wn_zero, rsvn_zero, rn1_zero, rn2_zero;
   logic wr_en, rsv_en, hit1, hit2;

   assign wn_zero   = ZERO_REG && (WN   == '0);
   assign rsvn_zero = ZERO_REG && (RsvN == '0);
   assign rn1_zero  = ZERO_REG && (RN1  == '0);
   assign rn2_zero  = ZERO_REG && (RN2  == '0);

   assign wr_en  = RegWrite && !wn_zero;
   assign rsv_en = Rsv && !rsvn_zero;
   assign hit1   = RegWrite && (WN == RN1);
   assign hit2   = RegWrite && (WN == RN2);

   // Release on write first, then reserve, so a same-edge new producer keeps the entry busy.
   always_comb begin
      busy_d     = busy_q;
      wr_unres_d = wr_unres_q;
      if (wr_en) begin
         busy_d[WN] = 1'b0;
         if (!busy_q[WN]) wr_unres_d = 1'b1;
      end
      if (rsv_en) busy_d[RsvN] = 1'b1;
   end

   always_comb begin
      busy_cnt_d = '0;
      for (int i = 0; i < DEPTH; i++) begin
         busy_cnt_d = busy_cnt_d + {{ADDR_W{1'b0}}, busy_d[i]};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         busy_q     <= '0;
         busy_cnt_q <= '0;
         wr_unres_q <= 1'b0;
      end else begin
         if (wr_en) mem_q[WN] <= WD;
         busy_q     <= busy_d;
         busy_cnt_q <= busy_cnt_d;
         wr_unres_q <= wr_unres_d;
      end
   end

   always_comb begin
      RD1   = '0;
      RD2   = '0;
      busy1 = 1'b0;
      busy2 = 1'b0;
      if (rst_n) begin
         if (!rn1_zero) begin
            RD1   = hit1 ? WD : mem_q[RN1];
            busy1 = busy_q[RN1] & ~hit1;
         end
         if (!rn2_zero) begin
            RD2   = hit2 ? WD : mem_q[RN2];
            busy2 = busy_q[RN2] & ~hit2;
         end
      end
   end

   assign busy_cnt = busy_cnt_q;
   assign wr_unres = wr_unres_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: directed scenarios plus a randomised scoreboard run.
module tb_reg_file_sb;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int DEPTH  = 2 ** ADDR_W;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              RegWrite;
   logic [ADDR_W-1:0] WN;
   logic [DATA_W-1:0] WD;
   logic [ADDR_W-1:0] RN1, RN2;
   logic [DATA_W-1:0] RD1, RD2;
   logic              Rsv;
   logic [ADDR_W-1:0] RsvN;
   logic              busy1, busy2;
   logic [ADDR_W:0]   busy_cnt;
   logic              wr_unres;

   logic [DATA_W-1:0] exp_q[$];
   logic [DATA_W-1:0] exp_v;
   int tests  = 0;
   int failed = 0;

   // reference state for the randomised run
   logic [DATA_W-1:0] mem_m [DEPTH];
   logic [DEPTH-1:0]  busy_m;
   logic              unres_m;

   reg_file_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .RegWrite(RegWrite), .WN(WN), .WD(WD),
      .RN1(RN1), .RN2(RN2), .RD1(RD1), .RD2(RD2), .Rsv(Rsv), .RsvN(RsvN),
      .busy1(busy1), .busy2(busy2), .busy_cnt(busy_cnt), .wr_unres(wr_unres)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // inputs change after the falling edge; one call advances through one rising edge
   task automatic cycle();
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   task automatic idle();
      RegWrite = 1'b0; WN = '0; WD = '0; Rsv = 1'b0; RsvN = '0;
   endtask

   task automatic test_reset();
      idle();
      rst_n = 1'b0; RN1 = 5'd3; RN2 = 5'd3;
      RegWrite = 1'b1; WN = 5'd3; WD = 32'hFFFF_FFFF; Rsv = 1'b1; RsvN = 5'd3;
      #1;
      exp_q.push_back(32'd0); exp_q.push_back(32'd0);
      exp_v = exp_q.pop_front(); tests++;
      if (RD1 !== exp_v) begin failed++; $display("FAIL reset_rd1: got %h want %h", RD1, exp_v); end
      exp_v = exp_q.pop_front(); tests++;
      if ({31'd0, busy1} !== exp_v) begin failed++; $display("FAIL reset_busy1: got %b want %h", busy1, exp_v); end
      cycle();
      idle(); rst_n = 1'b1;
      #1;
      exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
      exp_v = exp_q.pop_front(); tests++;
      if (RD1 !== exp_v) begin failed++; $display("FAIL reset_mem3: got %h want %h", RD1, exp_v); end
      exp_v = exp_q.pop_front(); tests++;
      if ({26'd0, busy_cnt} !== exp_v) begin failed++; $display("FAIL reset_busy_cnt: got %0d want %0d", busy_cnt, exp_v); end
      exp_v = exp_q.pop_front(); tests++;
      if ({31'd0, wr_unres} !== exp_v) begin failed++; $display("FAIL reset_wr_unres: got %b want %h", wr_unres, exp_v); end
   endtask

   task automatic test_reserve_bypass();
      idle(); Rsv = 1'b1; RsvN = 5'd7;
      cycle();
      idle(); RN1 = 5'd7;
      #1;
      exp_q.push_back(32'd1); exp_q.push_back(32'd1);
      exp_v = exp_q.pop_front(); tests++;
      if ({31'd0, busy1} !== exp_v) begin failed++; $display("FAIL rsv_busy1: got %b want %h", busy1, exp_v); end
      exp_v = exp_q.pop_front(); tests++;
      if ({26'd0, busy_cnt} !== exp_v) begin failed++; $display("FAIL rsv_busy_cnt: got %0d want %0d", busy_cnt, exp_v); end
      RegWrite = 1'b1; WN = 5'd7; WD = 32'hDEAD_BEEF;
      #1;
      exp_q.push_back(32'hDEAD_BEEF); exp_q.push_back(32'd0);
      exp_v = exp_q.pop_front(); tests++;
      if (RD1 !== exp_v) begin failed++; $display("FAIL bypass_rd1: got %h want %h", RD1, exp_v); end
      exp_v = exp_q.pop_front(); tests++;
      if ({31'd0, busy1} !== exp_v) begin failed++; $display("FAIL bypass_busy1: got %b want %h", busy1, exp_v); end
      cycle();
      idle();
      #1;
      exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'hDEAD_BEEF);
      exp_v = exp_q.pop_front(); tests++;
      if ({26'd0, busy_cnt} !== exp_v) begin failed++; $display("FAIL release_busy_cnt: got %0d want %0d", busy_cnt, exp_v); end
      exp_v = exp_q.pop_front(); tests++;
      if ({31'd0, wr_unres} !== exp_v) begin failed++; $display("FAIL release_wr_unres: got %b want %h", wr_unres, exp_v); end
      exp_v = exp_q.pop_front(); tests++;
      if (RD1 !== exp_v) begin failed++; $display("FAIL stored_rd1: got %h want %h", RD1, exp_v); end
   endtask

   task automatic test_zero_reg();
      idle(); RegWrite = 1'b1; WN = 5'd0; WD = 32'd5; Rsv = 1'b1; RsvN = 5'd0;
      RN1 = 5'd0; RN2 = 5'd0;
      #1;
      exp_q.push_back(32'd0); exp_q.push_back(32'd0);
      exp_v = exp_q.pop_front(); tests++;
      if (RD1 !== exp_v) begin failed++; $display("FAIL zero_bypass_rd1: got %h want %h", RD1, exp_v); end
      exp_v = exp_q.pop_front(); tests++;
      if ({31'd0, busy2} !== exp_v) begin failed++; $display("FAIL zero_busy2: got %b want %h", busy2, exp_v); end
      cycle();
      idle();
      #1;
      exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
      exp_v = exp_q.pop_front(); tests++;
      if (RD2 !== exp_v) begin failed++; $display("FAIL zero_rd2: got %h want %h", RD2, exp_v); end
      exp_v = exp_q.pop_front(); tests++;
      if ({26'd0, busy_cnt} !== exp_v) begin failed++; $display("FAIL zero_busy_cnt: got %0d want %0d", busy_cnt, exp_v); end
      exp_v = exp_q.pop_front(); tests++;
      if ({31'd0, wr_unres} !== exp_v) begin failed++; $display("FAIL zero_wr_unres: got %b want %h", wr_unres, exp_v); end
   endtask

   task automatic test_write_reserve_same();
      idle(); Rsv = 1'b1; RsvN = 5'd9;
      cycle();
      idle(); RegWrite = 1'b1; WN = 5'd9; WD = 32'h11; Rsv = 1'b1; RsvN = 5'd9;
      cycle();
      idle(); RN1 = 5'd9; RN2 = 5'd9;
      #1;
      exp_q.push_back(32'h11); exp_q.push_back(32'h11);
      exp_q.push_back(32'd1);  exp_q.push_back(32'd1);
      exp_q.push_back(32'd1);  exp_q.push_back(32'd0);
      exp_v = exp_q.pop_front(); tests++;
      if (RD1 !== exp_v) begin failed++; $display("FAIL same_rd1: got %h want %h", RD1, exp_v); end
      exp_v = exp_q.pop_front(); tests++;
      if (RD2 !== exp_v) begin failed++; $display("FAIL same_rd2: got %h want %h", RD2, exp_v); end
      exp_v = exp_q.pop_front(); tests++;
      if ({31'd0, busy1} !== exp_v) begin failed++; $display("FAIL same_busy1: got %b want %h", busy1, exp_v); end
      exp_v = exp_q.pop_front(); tests++;
      if ({31'd0, busy2} !== exp_v) begin failed++; $display("FAIL same_busy2: got %b want %h", busy2, exp_v); end
      exp_v = exp_q.pop_front(); tests++;
      if ({26'd0, busy_cnt} !== exp_v) begin failed++; $display("FAIL same_busy_cnt: got %0d want %0d", busy_cnt, exp_v); end
      exp_v = exp_q.pop_front(); tests++;
      if ({31'd0, wr_unres} !== exp_v) begin failed++; $display("FAIL same_wr_unres: got %b want %h", wr_unres, exp_v); end
   endtask

   task automatic test_wr_unres();
      idle(); RegWrite = 1'b1; WN = 5'd4; WD = 32'h22;
      cycle();
      idle(); RN1 = 5'd4;
      #1;
      exp_q.push_back(32'h22); exp_q.push_back(32'd1);
      exp_v = exp_q.pop_front(); tests++;
      if (RD1 !== exp_v) begin failed++; $display("FAIL unres_rd1: got %h want %h", RD1, exp_v); end
      exp_v = exp_q.pop_front(); tests++;
      if ({31'd0, wr_unres} !== exp_v) begin failed++; $display("FAIL unres_set: got %b want %h", wr_unres, exp_v); end
      // release the entry 9 producer; the sticky flag must not drop
      RegWrite = 1'b1; WN = 5'd9; WD = 32'h33;
      cycle();
      idle();
      cycle(); cycle();
      exp_q.push_back(32'd1); exp_q.push_back(32'd0);
      exp_v = exp_q.pop_front(); tests++;
      if ({31'd0, wr_unres} !== exp_v) begin failed++; $display("FAIL unres_sticky: got %b want %h", wr_unres, exp_v); end
      exp_v = exp_q.pop_front(); tests++;
      if ({26'd0, busy_cnt} !== exp_v) begin failed++; $display("FAIL unres_busy_cnt: got %0d want %0d", busy_cnt, exp_v); end
   endtask

   task automatic test_random();
      logic [DATA_W-1:0] e_rd1, e_rd2;
      logic              e_b1, e_b2;
      int                cnt;
      idle(); rst_n = 1'b0;
      cycle();
      rst_n = 1'b1;
      for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
      busy_m  = '0;
      unres_m = 1'b0;
      for (int n = 0; n < 300; n++) begin
         RegWrite = ($urandom_range(0, 1) == 1);
         WN       = ADDR_W'($urandom_range(0, DEPTH - 1));
         WD       = $urandom;
         Rsv      = ($urandom_range(0, 1) == 1);
         RsvN     = ADDR_W'($urandom_range(0, DEPTH - 1));
         RN1      = ($urandom_range(0, 3) == 0) ? WN : ADDR_W'($urandom_range(0, DEPTH - 1));
         RN2      = ($urandom_range(0, 3) == 0) ? RN1 : ADDR_W'($urandom_range(0, DEPTH - 1));
         e_rd1 = (RN1 == 0) ? '0 : ((RegWrite && WN == RN1) ? WD : mem_m[RN1]);
         e_rd2 = (RN2 == 0) ? '0 : ((RegWrite && WN == RN2) ? WD : mem_m[RN2]);
         e_b1  = (RN1 != 0) && busy_m[RN1] && !(RegWrite && WN == RN1);
         e_b2  = (RN2 != 0) && busy_m[RN2] && !(RegWrite && WN == RN2);
         exp_q.push_back(e_rd1); exp_q.push_back(e_rd2);
         exp_q.push_back({31'd0, e_b1}); exp_q.push_back({31'd0, e_b2});
         #1;
         exp_v = exp_q.pop_front(); tests++;
         if (RD1 !== exp_v) begin failed++; $display("FAIL rand_rd1[%0d]: got %h want %h", n, RD1, exp_v); end
         exp_v = exp_q.pop_front(); tests++;
         if (RD2 !== exp_v) begin failed++; $display("FAIL rand_rd2[%0d]: got %h want %h", n, RD2, exp_v); end
         exp_v = exp_q.pop_front(); tests++;
         if ({31'd0, busy1} !== exp_v) begin failed++; $display("FAIL rand_busy1[%0d]: got %b want %h", n, busy1, exp_v); end
         exp_v = exp_q.pop_front(); tests++;
         if ({31'd0, busy2} !== exp_v) begin failed++; $display("FAIL rand_busy2[%0d]: got %b want %h", n, busy2, exp_v); end
         if (RegWrite && WN != 0) begin
            mem_m[WN] = WD;
            if (!busy_m[WN]) unres_m = 1'b1;
            busy_m[WN] = 1'b0;
         end
         if (Rsv && RsvN != 0) busy_m[RsvN] = 1'b1;
         cnt = 0;
         for (int i = 0; i < DEPTH; i++) cnt += busy_m[i];
         exp_q.push_back(DATA_W'(cnt)); exp_q.push_back({31'd0, unres_m});
         cycle();
         exp_v = exp_q.pop_front(); tests++;
         if ({26'd0, busy_cnt} !== exp_v) begin failed++; $display("FAIL rand_busy_cnt[%0d]: got %0d want %0d", n, busy_cnt, exp_v); end
         exp_v = exp_q.pop_front(); tests++;
         if ({31'd0, wr_unres} !== exp_v) begin failed++; $display("FAIL rand_wr_unres[%0d]: got %b want %h", n, wr_unres, exp_v); end
      end
      idle();
   endtask

   task automatic test_full_and_reset();
      idle();
      for (int i = 1; i < DEPTH; i++) begin
         Rsv = 1'b1; RsvN = ADDR_W'(i);
         cycle();
      end
      Rsv = 1'b1; RsvN = 5'd5;
      cycle();
      idle();
      #1;
      exp_q.push_back(32'd31);
      exp_v = exp_q.pop_front(); tests++;
      if ({26'd0, busy_cnt} !== exp_v) begin failed++; $display("FAIL full_busy_cnt: got %0d want %0d", busy_cnt, exp_v); end
      rst_n = 1'b0; RegWrite = 1'b1; WN = 5'd12; WD = 32'hABCD_1234; Rsv = 1'b1; RsvN = 5'd12;
      cycle();
      idle(); rst_n = 1'b1; RN1 = 5'd12; RN2 = 5'd12;
      #1;
      exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
      exp_v = exp_q.pop_front(); tests++;
      if (RD1 !== exp_v) begin failed++; $display("FAIL rst_mem12: got %h want %h", RD1, exp_v); end
      exp_v = exp_q.pop_front(); tests++;
      if ({31'd0, busy2} !== exp_v) begin failed++; $display("FAIL rst_busy12: got %b want %h", busy2, exp_v); end
      exp_v = exp_q.pop_front(); tests++;
      if ({26'd0, busy_cnt} !== exp_v) begin failed++; $display("FAIL rst_busy_cnt: got %0d want %0d", busy_cnt, exp_v); end
      exp_v = exp_q.pop_front(); tests++;
      if ({31'd0, wr_unres} !== exp_v) begin failed++; $display("FAIL rst_wr_unres: got %b want %h", wr_unres, exp_v); end
   endtask

   initial begin
      idle(); rst_n = 1'b0; RN1 = '0; RN2 = '0;
      @(negedge clk);
      #1;
      test_reset();
      test_reserve_bypass();
      test_zero_reg();
      test_write_reserve_same();
      test_wr_unres();
      test_random();
      test_full_and_reset();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
